cacheline_adaptor: RTL
======================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter BEATS, default 4: bursts per cache line.
REQ-002 SHALL have parameter BEAT_W, default 64: bits per burst beat; line width is BEATS*BEAT_W (256).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit (see Configuration).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port line_i  input  256  write line from cache.
REQ-007 SHALL have port line_o  output  256  assembled read line to cache.
REQ-008 SHALL have port address_i  input  32  cache request address.
REQ-009 SHALL have port read_i  input  1  cache line-read request.
REQ-010 SHALL have port write_i  input  1  cache line-write request.
REQ-011 SHALL have port resp_o  output  1  one-cycle completion pulse to cache.
REQ-012 SHALL have port burst_i  input  64  read beat from memory.
REQ-013 SHALL have port burst_o  output  64  write beat to memory.
REQ-014 SHALL have port address_o  output  32  line-aligned memory address.
REQ-015 SHALL have port read_o  output  1  memory burst-read request.
REQ-016 SHALL have port write_o  output  1  memory burst-write request.
REQ-017 SHALL have port resp_i  input  1  memory beat-valid/accept strobe.
REQ-018 SHALL have port timeout_o  output  1  sticky watchdog flag.

Function
REQ-019 SHALL implement states IDLE, RD_BURST, WR_BURST, DONE, with a 2-bit beat counter.
REQ-020 In IDLE, write_i SHALL take priority over read_i when both are high; the request is accepted that cycle.
REQ-021 On accept, the block SHALL latch {address_i[31:5],5'b0} into address_o, latch line_i (write only), clear the counter, and enter RD_BURST or WR_BURST next cycle.
REQ-022 read_o SHALL be high exactly while in RD_BURST; write_o SHALL be high exactly while in WR_BURST.
REQ-023 In RD_BURST, each cycle with resp_i high SHALL store burst_i into line_o[64*cnt +: 64] and increment cnt.
REQ-024 In WR_BURST, burst_o SHALL equal line_latched[64*cnt +: 64] combinationally; each resp_i cycle increments cnt.
REQ-025 On the resp_i cycle with cnt==BEATS-1, the block SHALL enter DONE; read_o/write_o drop that next cycle.
REQ-026 DONE SHALL assert resp_o for exactly one cycle, with line_o stable and complete for reads, then return to IDLE.
REQ-027 resp_i low cycles inside a burst SHALL stall cnt without error (non-consecutive beats allowed).
REQ-028 resp_i in IDLE or DONE SHALL be ignored; read_i/write_i outside IDLE SHALL be ignored (not queued).
REQ-029 line_o SHALL hold its last value until the next read burst overwrites it; address_o holds until next accept.
REQ-030 Minimum request-to-resp_o latency SHALL be BEATS+2 cycles (accept, 4 beats, DONE).

Reset
REQ-031 When rst is high at a clock edge, the block SHALL enter IDLE and clear cnt, resp_o, read_o, write_o, timeout_o, address_o, line_o and burst_o to 0, including mid-burst.
REQ-032 A request asserted in the same cycle as rst SHALL be dropped.

Configuration
REQ-033 Macro CACHELINE_ADAPTOR_TIMEOUT_EN, when defined, SHALL add a counter that clears on every resp_i or state change and increments each RD_BURST/WR_BURST cycle without resp_i.
REQ-034 With the macro defined, the counter reaching TIMEOUT_CYCLES SHALL set timeout_o (sticky until rst) and force IDLE next cycle without asserting resp_o.
REQ-035 Without the macro, timeout_o SHALL be tied 0 and no watchdog logic SHALL exist; bursts wait indefinitely.

Verification
REQ-036 Read at address_i=0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles -> address_o=0x0000_1220, read_o high 4 cycles, resp_o pulse at cycle 6, line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-037 Write line_i=256'h0123...CDEF at 0x0000_0040 -> write_o high, burst_o presents line_i[63:0] through [255:192] in order on each resp_i, resp_o one cycle after last beat.
REQ-038 Read with resp_i gaps (pattern 1,0,0,1,1,0,1) -> correct line assembly, resp_o one cycle after the 4th beat.
REQ-039 read_i and write_i both high in IDLE -> write burst executes; read_i raised mid-burst -> ignored, no second transaction.
REQ-040 rst asserted after 2 read beats -> next cycle IDLE, read_o=0, resp_o never pulses; new read then completes normally.
REQ-041 With CACHELINE_ADAPTOR_TIMEOUT_EN and TIMEOUT_CYCLES=8, read with no resp_i -> timeout_o high after 8 stalled cycles, read_o drops, resp_o stays 0, timeout_o held until rst.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cache-line <-> memory burst adaptor; optional watchdog under `CACHELINE_ADAPTOR_TIMEOUT_EN.
// Latency: request-to-resp_o is BEATS+2 cycles minimum (accept, one cycle per beat, DONE).
// Backpressure: resp_i low stalls the beat counter; requests are only sampled in IDLE.
module cacheline_adaptor #(
    parameter int BEATS          = 4,
    parameter int BEAT_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BEATS*BEAT_W-1:0] line_i,
    output logic [BEATS*BEAT_W-1:0] line_o,
    input  logic [31:0]             address_i,
    input  logic                    read_i,
    input  logic                    write_i,
    output logic                    resp_o,
    input  logic [BEAT_W-1:0]       burst_i,
    output logic [BEAT_W-1:0]       burst_o,
    output logic [31:0]             address_o,
    output logic                    read_o,
    output logic                    write_o,
    input  logic                    resp_i,
    output logic                    timeout_o
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [BEATS*BEAT_W-1:0] line_q;
    logic                    accept_rd;
    logic                    accept_wr;
    logic                    in_burst;
    logic                    last_beat;
    logic                    wd_expire;

    assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        case (state)
            IDLE: begin
                // Write wins when the cache raises both in the same cycle.
                if (write_i) begin
                    accept_wr = 1'b1;
                    state_nxt = WR_BURST;
                end else if (read_i) begin
                    accept_rd = 1'b1;
                    state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (wd_expire)              state_nxt = IDLE;
                else if (resp_i && last_beat) state_nxt = DONE;
            end
            WR_BURST: begin
                write_o = 1'b1;
                if (wd_expire)              state_nxt = IDLE;
                else if (resp_i && last_beat) state_nxt = DONE;
            end
            DONE: begin
                resp_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            address_o <= '0;
            line_o    <= '0;
            line_q    <= '0;
        end else begin
            if (accept_rd || accept_wr) begin
                cnt       <= '0;
                address_o <= {address_i[31:5], 5'b0};
            end else if (in_burst && resp_i) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept_wr) line_q <= line_i;
            if ((state == RD_BURST) && resp_i) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (cnt == CNT_W'(b)) line_o[b*BEAT_W +: BEAT_W] <= burst_i;
                end
            end
        end
    end

    // Outgoing write beat follows the counter with no register stage.
    always_comb begin
        burst_o = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt == CNT_W'(b)) burst_o = line_q[b*BEAT_W +: BEAT_W];
        end
    end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Fires on the stalled cycle that would bring the count to TIMEOUT_CYCLES.
    assign wd_expire = in_burst && !resp_i && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_burst && !resp_i && !wd_expire) wd_cnt <= wd_cnt + WD_W'(1);
            else                                   wd_cnt <= '0;
            if (wd_expire) timeout_q <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule
